// File: rtl/bw_to_color_if.sv
// Memory-side bus for bw_to_color: grayscale read port, image write port
// and, when CORNER_OVERLAY_EN is defined, the corner-map read port.
// master = the converter, slave = the SRAM side.
interface bw_to_color_if #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 24
);
    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;

    logic                   ren_bw;
    logic [XW-1:0]          x_addr_bw;
    logic [YW-1:0]          y_addr_bw;
    logic [7:0]             rdat_bw;
    logic                   wen_img;
    logic [XW-1:0]          x_addr_img;
    logic [YW-1:0]          y_addr_img;
    logic [PIXEL_DEPTH-1:0] wdat_img;
`ifdef CORNER_OVERLAY_EN
    logic                   ren_corner;
    logic [XW-1:0]          x_addr_corner;
    logic [YW-1:0]          y_addr_corner;
    logic                   rdat_corner;
`endif

    modport master (
`ifdef CORNER_OVERLAY_EN
        output ren_corner, x_addr_corner, y_addr_corner,
        input  rdat_corner,
`endif
        output ren_bw, x_addr_bw, y_addr_bw,
        input  rdat_bw,
        output wen_img, x_addr_img, y_addr_img, wdat_img
    );

    modport slave (
`ifdef CORNER_OVERLAY_EN
        input  ren_corner, x_addr_corner, y_addr_corner,
        output rdat_corner,
`endif
        input  ren_bw, x_addr_bw, y_addr_bw,
        output rdat_bw,
        input  wen_img, x_addr_img, y_addr_img, wdat_img
    );
endinterface

// File: rtl/bw_to_color.sv
// Grayscale -> 24-bit image copy. Walks the frame in raster order at one
// pixel per cycle: read stage issues (x,y) to the gray SRAM, write stage
// one cycle later writes {g,g,g} to the image SRAM using the raw read data.
// Optional macro CORNER_OVERLAY_EN: reads the corner map in lockstep and
// writes a red marker (24'hFF0000) where a corner is flagged.
// PIXEL_DEPTH must be 24.
module bw_to_color #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          color_done,
    bw_to_color_if.master bus
);
    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state, state_nx;
    logic [XW-1:0] x, x_d;
    logic [YW-1:0] y, y_d;
    logic          valid_d;
    logic          last_px;
    logic          x_last;
    logic          rd_en;
    logic [23:0]   pix;

    assign x_last  = (x == XW'(X_MAX - 1));
    assign last_px = x_last && (y == YW'(Y_MAX - 1));
    assign rd_en   = (state == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: abort beats everything except reset; start only seen in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (abort) state_nx = IDLE;
                     else if (last_px) state_nx = FLUSH;
            FLUSH:   state_nx = abort ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Raster counters; hold at the final pixel instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE && start) begin
            x <= '0;
            y <= '0;
        end else if (rd_en && abort) begin
            x <= '0;
            y <= '0;
        end else if (rd_en && !last_px) begin
            if (x_last) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // Write-stage capture of the read request; an abort kills the in-flight pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0;
            x_d     <= '0;
            y_d     <= '0;
        end else begin
            valid_d <= rd_en && !abort;
            x_d     <= x;
            y_d     <= y;
        end
    end

`ifdef CORNER_OVERLAY_EN
    assign pix = bus.rdat_corner ? 24'hFF0000 : {3{bus.rdat_bw}};

    assign bus.ren_corner    = rd_en;
    assign bus.x_addr_corner = rd_en ? x : '0;
    assign bus.y_addr_corner = rd_en ? y : '0;
`else
    assign pix = {3{bus.rdat_bw}};
`endif

    // Addresses and data are forced to zero whenever their enable is low
    assign bus.ren_bw     = rd_en;
    assign bus.x_addr_bw  = rd_en ? x : '0;
    assign bus.y_addr_bw  = rd_en ? y : '0;
    assign bus.wen_img    = valid_d;
    assign bus.x_addr_img = valid_d ? x_d : '0;
    assign bus.y_addr_img = valid_d ? y_d : '0;
    assign bus.wdat_img   = valid_d ? PIXEL_DEPTH'(pix) : '0;

    assign busy       = (state == RUN) || (state == FLUSH);
    assign color_done = (state == DONE);
endmodule

// File: tb/tb_bw_to_color.sv
// Bench for bw_to_color on a 4x3 frame. Stimulus queues expected image
// writes; a negedge monitor pops and compares every wen_img beat.
module tb_bw_to_color;
    localparam int XM = 4;
    localparam int YM = 3;
    localparam int N  = XM * YM;
    localparam int XW = $clog2(XM) + 1;
    localparam int YW = $clog2(YM) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, color_done;

    bw_to_color_if #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(24)) bus ();

    bw_to_color #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .color_done (color_done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [23:0]   d;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] pat_base  = 8'h00;
    bit         pat_const = 1'b0;
    int         corner_x  = -1;
    int         corner_y  = -1;

    function automatic logic [7:0] pix(input logic [XW-1:0] xx, input logic [YW-1:0] yy);
        if (pat_const) return pat_base;
        return pat_base + 8'(xx) + 8'({yy, 2'b00});
    endfunction

    // Gray SRAM (and corner map) with one cycle of read latency
    always @(posedge clk) begin
        if (bus.ren_bw) bus.rdat_bw <= pix(bus.x_addr_bw, bus.y_addr_bw);
`ifdef CORNER_OVERLAY_EN
        if (bus.ren_corner)
            bus.rdat_corner <= (int'(bus.x_addr_corner) == corner_x) &&
                               (int'(bus.y_addr_corner) == corner_y);
`endif
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: every image write must match the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wen_img) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write x=%0d y=%0d d=%h", bus.x_addr_img,
                             bus.y_addr_img, bus.wdat_img);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({bus.x_addr_img, bus.y_addr_img, bus.wdat_img} !== e) begin
                        failures++;
                        $display("FAIL write got=(%0d,%0d,%h) want=(%0d,%0d,%h)",
                                 bus.x_addr_img, bus.y_addr_img, bus.wdat_img, e.x, e.y, e.d);
                    end
                end
            end
            checks++;
            if ((!bus.ren_bw && (bus.x_addr_bw != 0 || bus.y_addr_bw != 0)) ||
                (!bus.wen_img && (bus.x_addr_img != 0 || bus.y_addr_img != 0 ||
                                  bus.wdat_img != 0))) begin
                failures++;
                $display("FAIL idle_addr_zero rd=(%0d,%0d) wr=(%0d,%0d,%h)", bus.x_addr_bw,
                         bus.y_addr_bw, bus.x_addr_img, bus.y_addr_img, bus.wdat_img);
            end
`ifdef CORNER_OVERLAY_EN
            checks++;
            if ({bus.ren_corner, bus.x_addr_corner, bus.y_addr_corner} !==
                {bus.ren_bw, bus.x_addr_bw, bus.y_addr_bw}) begin
                failures++;
                $display("FAIL corner_lockstep got=%b,%0d,%0d want=%b,%0d,%0d",
                         bus.ren_corner, bus.x_addr_corner, bus.y_addr_corner,
                         bus.ren_bw, bus.x_addr_bw, bus.y_addr_bw);
            end
`endif
        end
    end

    task automatic push_px(input int i, input logic [23:0] d);
        exp_q.push_back({XW'(i % XM), YW'(i / XM), d});
    endtask

    // One frame: start sampled at edge 0, then cycles 1..N+4 checked at negedge.
    // abort_cyc/rst_cyc/s1/s2 name the cycle on which that input is high (0 = never).
    task automatic run_frame(input string tag, input int abort_cyc, input int rst_cyc,
                             input int s1, input int s2);
        int stop;
        logic [9:0] act, expv;
        logic b_e, r_e, w_e, d_e;
        stop = 1000;
        if (abort_cyc > 0) stop = abort_cyc;
        if (rst_cyc > 0) stop = rst_cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            b_e  = (k <= N + 1) && (k <= stop);
            r_e  = (k <= N) && (k <= stop);
            w_e  = (k >= 2) && (k <= N + 1) && (k <= stop);
            d_e  = (k == N + 2) && (stop > N + 2);
            expv = {b_e, r_e, w_e, d_e,
                    r_e ? 3'((k - 1) % XM) : 3'd0,
                    r_e ? 3'((k - 1) / XM) : 3'd0};
            act  = {busy, bus.ren_bw, bus.wen_img, color_done, bus.x_addr_bw, bus.y_addr_bw};
            chk($sformatf("%s_cyc%0d", tag, k), 64'(act), 64'(expv));
            abort = (k == abort_cyc);
            rst   = (k == rst_cyc);
            start = (k == s1) || (k == s2);
        end
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 64'({busy, color_done, bus.ren_bw, bus.wen_img}), 64'd0);
        chk("rst_addr", 64'({bus.x_addr_bw, bus.y_addr_bw, bus.x_addr_img, bus.y_addr_img}), 64'd0);
        chk("rst_wdat", 64'(bus.wdat_img), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Frame A: first pixel 5A -> 5A5A5A, rest 5A+i
        pat_base = 8'h5A;
        push_px(0, 24'h5A5A5A);
        for (int i = 1; i < N; i++) push_px(i, {3{8'(8'h5A + i)}});
        run_frame("frameA", 0, 0, 0, 0);

        // Frame B: gray = x+4y, start pulses in RUN (5) and DONE (14) ignored
        pat_base = 8'h00;
        for (int i = 0; i < N; i++) push_px(i, {3{8'(i)}});
        run_frame("frameB", 0, 0, 5, 14);

        // Frame C: fresh start from IDLE
        for (int i = 0; i < N; i++) push_px(i, {3{8'(i)}});
        run_frame("frameC", 0, 0, 0, 0);

        // Abort on cycle 5: pixels 0..3 only, no color_done
        for (int i = 0; i < 4; i++) push_px(i, {3{8'(i)}});
        run_frame("abort", 5, 0, 0, 0);

        // Reset on cycle 7: pixels 0..5 written, then silence
        for (int i = 0; i < 6; i++) push_px(i, {3{8'(i)}});
        run_frame("midrst", 0, 7, 0, 0);
        for (int i = 0; i < N; i++) push_px(i, {3{8'(i)}});
        run_frame("after_rst", 0, 0, 0, 0);

`ifdef CORNER_OVERLAY_EN
        // Corner at (2,1) = pixel 6 becomes red, the rest 404040
        pat_const = 1'b1;
        pat_base  = 8'h40;
        corner_x  = 2;
        corner_y  = 1;
        for (int i = 0; i < N; i++) push_px(i, (i == 6) ? 24'hFF0000 : 24'h404040);
        run_frame("corner", 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
